// File: rtl/bcd_display_scanner_pkg.sv
// Shared types and segment patterns for the BCD display scanner.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package bcd_disp_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_0     = 7'b0111111;
  localparam seg7_t SEG_1     = 7'b0000110;
  localparam seg7_t SEG_2     = 7'b1011011;
  localparam seg7_t SEG_3     = 7'b1001111;
  localparam seg7_t SEG_4     = 7'b1100110;
  localparam seg7_t SEG_5     = 7'b1101101;
  localparam seg7_t SEG_6     = 7'b1111101;
  localparam seg7_t SEG_7     = 7'b0000111;
  localparam seg7_t SEG_8     = 7'b1111111;
  localparam seg7_t SEG_9     = 7'b1101111;
  localparam seg7_t SEG_E     = 7'b1111001;
  localparam seg7_t SEG_BLANK = 7'b0000000;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } scan_state_t;

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Digit load and multiplexed 7-segment bus of the display scanner.
// master drives digits/load, slave is the scanner.
interface bcd_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    load;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    pending;
  logic                    frame_done;

  modport master (
    output bcd_in, load,
    input  seg, an, pending, frame_done
  );

  modport slave (
    input  bcd_in, load,
    output seg, an, pending, frame_done
  );

endinterface

// File: rtl/bcd_display_scanner_seg7.sv
// Combinational BCD nibble to 7-segment pattern decoder.
// Nibbles above 9 show the letter E.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG_E;
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Frame-safe BCD buffer and time-multiplexed 7-segment scanner.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter  int NUM_DIGITS = 4,
  parameter  int PRESCALE   = 4,
  localparam int CNT_W      = $clog2(PRESCALE + 1)
) (
  input logic                   clk,
  input logic                   clear,
  bcd_display_scanner_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DW    = 4 * NUM_DIGITS;

  scan_state_t state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DW-1:0]         disp_q, disp_d;
  logic [DW-1:0]         pend_q, pend_d;
  logic                  pending_q, pending_d;
  logic                  fd_q, fd_d;
  seg7_t                 seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  boundary;
  logic [3:0]            digit;
  seg7_t                 seg_dec;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    disp_d    = disp_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    boundary  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
        cnt_d   = '0;
        idx_d   = '0;
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(PRESCALE - 1)) begin
          cnt_d = '0;
          if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A load on the wrap edge bypasses the pending buffer
    if (boundary) begin
      if (bus.load) begin
        disp_d    = bus.bcd_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = pend_q;
        pending_d = 1'b0;
      end
    end else if (bus.load) begin
      pend_d    = bus.bcd_in;
      pending_d = 1'b1;
    end
    fd_d = boundary;
  end

  assign digit = disp_d[4*idx_d +: 4];

  bcd_to_seg7 u_dec (
    .bcd (digit),
    .seg (seg_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic lz;
`endif

  always_comb begin
    seg_d = seg_dec;
    an_d  = NUM_DIGITS'(1) << idx_d;
`ifdef LEADING_ZERO_BLANK_EN
    lz = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(idx_d) && disp_d[4*k +: 4] != 4'd0) lz = 1'b0;
    end
    if (lz && idx_d != '0) seg_d = SEG_BLANK;
`endif
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      disp_q    <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
      fd_q      <= 1'b0;
      seg_q     <= SEG_BLANK;
      an_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      disp_q    <= disp_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      fd_q      <= fd_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.pending    = pending_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner against a time-based model.
// Model derives the digit from elapsed cycles since reset release.
module tb_bcd_display_scanner;

  localparam int N = 4;
  localparam int P = 4;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  bcd_display_scanner_if #(.NUM_DIGITS(N)) bus ();

  bcd_display_scanner #(
    .NUM_DIGITS (N),
    .PRESCALE   (P)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct {
    logic [6:0]   seg;
    logic [N-1:0] an;
    logic         pend;
    logic         fd;
    int           t;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;

  bit           run;
  int           t;
  logic [4*N-1:0] disp, pendv;
  bit           pending;
  logic [6:0]   dec_tab [16];

  task automatic check(input string name, input int tt,
                       input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s t=%0d actual=%0h expected=%0h",
                  name, tt, act, exp);
  endtask

  function automatic logic [6:0] exp_seg(input int d);
    int v;
    v = int'((disp >> (4*d)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (disp >> (4*d)) == 0) return 7'b0000000;
`endif
    return dec_tab[v];
  endfunction

  always @(negedge clk) begin
    if (clear && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("seg",        e.t, int'(bus.seg),        int'(e.seg));
      check("an",         e.t, int'(bus.an),         int'(e.an));
      check("pending",    e.t, int'(bus.pending),    int'(e.pend));
      check("frame_done", e.t, int'(bus.frame_done), int'(e.fd));
    end
  end

  task automatic cycle(input bit ld, input logic [4*N-1:0] v);
    exp_t e;
    bit bnd;
    int d;
    bus.load   = ld;
    bus.bcd_in = v;
    if (!run) begin
      run = 1;
      t   = 0;
    end else begin
      t++;
    end
    bnd = (t > 0) && (t % (N*P) == 0);
    if (bnd) begin
      if (ld) begin
        disp    = v;
        pending = 0;
      end else if (pending) begin
        disp    = pendv;
        pending = 0;
      end
    end else if (ld) begin
      pendv   = v;
      pending = 1;
    end
    d      = (t / P) % N;
    e.seg  = exp_seg(d);
    e.an   = N'(1) << d;
    e.pend = pending;
    e.fd   = bnd;
    e.t    = t;
    @(posedge clk);
    #2;
    q.push_back(e);
    bus.load = 1'b0;
  endtask

  task automatic model_reset();
    run     = 0;
    t       = 0;
    disp    = '0;
    pendv   = '0;
    pending = 0;
  endtask

  task automatic check_reset_outputs(input int tag);
    check("rst_seg",     tag, int'(bus.seg),        0);
    check("rst_an",      tag, int'(bus.an),         0);
    check("rst_pending", tag, int'(bus.pending),    0);
    check("rst_fd",      tag, int'(bus.frame_done), 0);
  endtask

  function automatic logic [4*N-1:0] rand_val();
    logic [4*N-1:0] r;
    r = 16'($urandom);
    case ($urandom % 3)
      0:       return r;
      1:       return r & 16'h00FF;
      default: return 16'h0000;
    endcase
  endfunction

  initial begin
    dec_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                7'b1111111, 7'b1101111, 7'b1111001, 7'b1111001,
                7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001};
    model_reset();
    clear      = 1'b0;
    bus.load   = 1'b0;
    bus.bcd_in = '0;
    #1;
    check_reset_outputs(-1);
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs(-2);
    clear = 1'b1;

    for (int i = 0; i < 400; i++) begin
      bit ld;
      logic [4*N-1:0] v;
      ld = 1'b0;
      v  = '0;
      unique case (1'b1)
        (i == 0):   begin ld = 1; v = 16'h1234; end
        (i == 21):  begin ld = 1; v = 16'h5678; end
        (i == 48):  begin ld = 1; v = 16'h0009; end
        (i == 70):  begin ld = 1; v = 16'hA000; end
        (i == 100): begin ld = 1; v = 16'h0047; end
        (i == 130): begin ld = 1; v = 16'h0000; end
        (i >= 160): begin
          ld = ($urandom % 5) == 0;
          v  = rand_val();
        end
        default: ;
      endcase
      cycle(ld, v);
    end

    for (int k = 0; k < 2*N*P; k++) begin
      if (((t / P) % N) == 2) break;
      cycle(1'b0, '0);
    end
    check("mid_idx", t, (t / P) % N, 2);
    clear = 1'b0;
    #1;
    check_reset_outputs(t);
    q.delete();
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs(-3);
    clear = 1'b1;

    for (int i = 0; i < 200; i++) begin
      bit ld;
      ld = ($urandom % 4) == 0;
      cycle(ld, rand_val());
    end

    #10;
    check("queue_drained", t, q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
